// File: rtl/cu_issue.sv
// -----------------------------------------------------------------------------
// cu_issue -- single-issue dispatcher for the ALU, multiplier, shifter and
// bus-load (BC) paths of a compute unit.
//
// One 32-bit instruction is taken per handshake. The cycle after acceptance
// (issue cycle E) drives the chosen unit's enable, its control fields and the
// read addresses. L cycles later (ALU/SHF/BC: 1, MUL: 2) the writeback cycle W
// drives the write address and a single write enable on the crossbar.
//
// Handshake: instr is taken on a rising edge where instr_valid and
// instr_ready are both 1. The source holds instr stable while instr_valid is
// 1 and instr_ready is 0. instr_ready never depends on instr_valid.
//
// Optional feature: define CU_ISSUE_HAZARD_EN to add a read-after-write
// interlock against writebacks that have not yet committed. Without it only
// the structural writeback-port stall is applied.
//
// Ports
//   clk                 in   rising-edge clock
//   reset               in   asynchronous active-low reset
//   instr[31:0]         in   instruction word
//   instr_valid         in   instruction present
//   instr_ready         out  instruction can be accepted this cycle
//   ps_alu_*            out  ALU enable and controls (E cycle only)
//   ps_mul_*            out  multiplier enable and controls (E cycle only)
//   ps_shf_*            out  shifter enable and controls (E cycle only)
//   ps_xb_raddx/raddy   out  read addresses (E cycle only)
//   ps_xb_wadd          out  write address (updated in W, held otherwise)
//   ps_xb_w_cuEn        out  one-hot write source: bit0 ALU, bit1 SHF, bit2 MUL
//   ps_xb_w_bcEn        out  bus-data write enable
//   busy                out  an accepted instruction has not yet written back
// -----------------------------------------------------------------------------
module cu_issue #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int SIGNAL_WIDTH  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    output logic                     ps_alu_en,
    output logic                     ps_alu_log,
    output logic [1:0]               ps_alu_hc,
    output logic [2:0]               ps_alu_sc,
    output logic                     ps_alu_sat,
    output logic                     ps_mul_en,
    output logic                     ps_mul_otreg,
    output logic [3:0]               ps_mul_dtsts,
    output logic [1:0]               ps_mul_cls,
    output logic [1:0]               ps_mul_sc,
    output logic                     ps_shf_en,
    output logic [1:0]               ps_shf_cls,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_wadd,
    output logic [SIGNAL_WIDTH-1:0]  ps_xb_w_cuEn,
    output logic                     ps_xb_w_bcEn,
    output logic                     busy
);

    typedef enum logic [1:0] {
        UNIT_ALU = 2'b00,
        UNIT_MUL = 2'b01,
        UNIT_SHF = 2'b10,
        UNIT_BC  = 2'b11
    } unit_e;

    // Set on the first edge after reset release; keeps ready low until then.
    logic                     r_run;

    // Writeback scoreboard: slot 1 writes back next cycle, slot 2 the cycle
    // after. Both shift toward slot 1 every cycle.
    logic                     r_s1_v;
    logic [ADDRESS_WIDTH-1:0] r_s1_wadd;
    unit_e                    r_s1_src;
    logic                     r_s2_v;
    logic [ADDRESS_WIDTH-1:0] r_s2_wadd;
    unit_e                    r_s2_src;

    // Issue-cycle registers
    logic                     r_alu_en;
    logic                     r_alu_log;
    logic [1:0]               r_alu_hc;
    logic [2:0]               r_alu_sc;
    logic                     r_alu_sat;
    logic                     r_mul_en;
    logic                     r_mul_otreg;
    logic [3:0]               r_mul_dtsts;
    logic [1:0]               r_mul_cls;
    logic [1:0]               r_mul_sc;
    logic                     r_shf_en;
    logic [1:0]               r_shf_cls;
    logic [ADDRESS_WIDTH-1:0] r_raddx;
    logic [ADDRESS_WIDTH-1:0] r_raddy;

    // Writeback-cycle registers
    logic [ADDRESS_WIDTH-1:0] r_wadd;
    logic [SIGNAL_WIDTH-1:0]  r_cu_en;
    logic                     r_bc_en;

    // Decode of the candidate instruction
    unit_e                    w_unit;
    logic [ADDRESS_WIDTH-1:0] w_wadd;
    logic [ADDRESS_WIDTH-1:0] w_raddx;
    logic [ADDRESS_WIDTH-1:0] w_raddy;
    logic                     w_is_mul;
    logic                     w_reads;
    logic                     w_struct_stall;
    logic                     w_raw_stall;
    logic                     w_accept;
    logic                     w_unused_bits;

    assign w_unit   = unit_e'(instr[31:30]);
    assign w_wadd   = ADDRESS_WIDTH'(instr[11:8]);
    assign w_raddx  = ADDRESS_WIDTH'(instr[7:4]);
    assign w_raddy  = ADDRESS_WIDTH'(instr[3:0]);
    assign w_is_mul = (w_unit == UNIT_MUL);
    assign w_reads  = (w_unit != UNIT_BC);   // bus loads read no register

    assign w_unused_bits = ^instr[20:12];

    // A one-cycle instruction would land in slot 1 after the shift, which is
    // exactly where an occupied slot 2 is moving. A MUL lands in slot 2, which
    // is always empty after the shift, so it never stalls structurally.
    assign w_struct_stall = !w_is_mul && r_s2_v;

`ifdef CU_ISSUE_HAZARD_EN
    // Any valid slot is a write that has not committed by the time the
    // candidate would read in its issue cycle.
    assign w_raw_stall = w_reads &&
        ((r_s1_v && ((r_s1_wadd == w_raddx) || (r_s1_wadd == w_raddy))) ||
         (r_s2_v && ((r_s2_wadd == w_raddx) || (r_s2_wadd == w_raddy))));
`else
    assign w_raw_stall = 1'b0;
`endif

    assign instr_ready = r_run && !w_struct_stall && !w_raw_stall;
    assign w_accept    = instr_valid && instr_ready;

    function automatic logic [SIGNAL_WIDTH-1:0] cu_onehot(input unit_e src);
        logic [SIGNAL_WIDTH-1:0] v;
        v = '0;
        case (src)
            UNIT_ALU: v[0] = 1'b1;
            UNIT_SHF: v[1] = 1'b1;
            UNIT_MUL: v[2] = 1'b1;
            default:  v = '0;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run       <= 1'b0;
            r_s1_v      <= 1'b0;
            r_s1_wadd   <= '0;
            r_s1_src    <= UNIT_ALU;
            r_s2_v      <= 1'b0;
            r_s2_wadd   <= '0;
            r_s2_src    <= UNIT_ALU;
            r_alu_en    <= 1'b0;
            r_alu_log   <= 1'b0;
            r_alu_hc    <= '0;
            r_alu_sc    <= '0;
            r_alu_sat   <= 1'b0;
            r_mul_en    <= 1'b0;
            r_mul_otreg <= 1'b0;
            r_mul_dtsts <= '0;
            r_mul_cls   <= '0;
            r_mul_sc    <= '0;
            r_shf_en    <= 1'b0;
            r_shf_cls   <= '0;
            r_raddx     <= '0;
            r_raddy     <= '0;
            r_wadd      <= '0;
            r_cu_en     <= '0;
            r_bc_en     <= 1'b0;
        end else begin
            r_run <= 1'b1;

            // Scoreboard shift, then insert the accepted instruction at its
            // latency slot.
            r_s1_v    <= r_s2_v;
            r_s1_wadd <= r_s2_wadd;
            r_s1_src  <= r_s2_src;
            r_s2_v    <= 1'b0;
            if (w_accept) begin
                if (w_is_mul) begin
                    r_s2_v    <= 1'b1;
                    r_s2_wadd <= w_wadd;
                    r_s2_src  <= w_unit;
                end else begin
                    r_s1_v    <= 1'b1;
                    r_s1_wadd <= w_wadd;
                    r_s1_src  <= w_unit;
                end
            end

            // Writeback: slot 1 becomes the W cycle. wadd holds between writes.
            r_cu_en <= '0;
            r_bc_en <= 1'b0;
            if (r_s1_v) begin
                r_wadd <= r_s1_wadd;
                if (r_s1_src == UNIT_BC) begin
                    r_bc_en <= 1'b1;
                end else begin
                    r_cu_en <= cu_onehot(r_s1_src);
                end
            end

            // Issue cycle: everything returns to zero unless a new issue.
            r_alu_en    <= 1'b0;
            r_alu_log   <= 1'b0;
            r_alu_hc    <= '0;
            r_alu_sc    <= '0;
            r_alu_sat   <= 1'b0;
            r_mul_en    <= 1'b0;
            r_mul_otreg <= 1'b0;
            r_mul_dtsts <= '0;
            r_mul_cls   <= '0;
            r_mul_sc    <= '0;
            r_shf_en    <= 1'b0;
            r_shf_cls   <= '0;
            r_raddx     <= '0;
            r_raddy     <= '0;
            if (w_accept) begin
                case (w_unit)
                    UNIT_ALU: begin
                        r_alu_en  <= 1'b1;
                        r_alu_log <= instr[29];
                        r_alu_hc  <= instr[28:27];
                        r_alu_sc  <= instr[26:24];
                        r_alu_sat <= instr[23];
                    end
                    UNIT_MUL: begin
                        r_mul_en    <= 1'b1;
                        r_mul_otreg <= instr[29];
                        r_mul_dtsts <= instr[28:25];
                        r_mul_cls   <= instr[24:23];
                        r_mul_sc    <= instr[22:21];
                    end
                    UNIT_SHF: begin
                        r_shf_en  <= 1'b1;
                        r_shf_cls <= instr[29:28];
                    end
                    default: ;
                endcase
                if (w_reads) begin
                    r_raddx <= w_raddx;
                    r_raddy <= w_raddy;
                end
            end
        end
    end

    assign ps_alu_en    = r_alu_en;
    assign ps_alu_log   = r_alu_log;
    assign ps_alu_hc    = r_alu_hc;
    assign ps_alu_sc    = r_alu_sc;
    assign ps_alu_sat   = r_alu_sat;
    assign ps_mul_en    = r_mul_en;
    assign ps_mul_otreg = r_mul_otreg;
    assign ps_mul_dtsts = r_mul_dtsts;
    assign ps_mul_cls   = r_mul_cls;
    assign ps_mul_sc    = r_mul_sc;
    assign ps_shf_en    = r_shf_en;
    assign ps_shf_cls   = r_shf_cls;
    assign ps_xb_raddx  = r_raddx;
    assign ps_xb_raddy  = r_raddy;
    assign ps_xb_wadd   = r_wadd;
    assign ps_xb_w_cuEn = r_cu_en;
    assign ps_xb_w_bcEn = r_bc_en;

    // Every instruction in E also occupies a slot, so the slots alone cover it.
    assign busy = r_s1_v || r_s2_v;

endmodule

// File: tb/tb_cu_issue.sv
// -----------------------------------------------------------------------------
// Testbench for cu_issue. A reference model keeps the list of accepted
// instructions with their issue and writeback cycle numbers and derives every
// expected output, including instr_ready, from that list each cycle.
// -----------------------------------------------------------------------------
module tb_cu_issue;

    localparam int AW = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   instr = '0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic          ps_alu_en, ps_alu_log, ps_alu_sat;
    logic [1:0]    ps_alu_hc;
    logic [2:0]    ps_alu_sc;
    logic          ps_mul_en, ps_mul_otreg;
    logic [3:0]    ps_mul_dtsts;
    logic [1:0]    ps_mul_cls, ps_mul_sc;
    logic          ps_shf_en;
    logic [1:0]    ps_shf_cls;
    logic [AW-1:0] ps_xb_raddx, ps_xb_raddy, ps_xb_wadd;
    logic [SW-1:0] ps_xb_w_cuEn;
    logic          ps_xb_w_bcEn;
    logic          busy;

    cu_issue #(.ADDRESS_WIDTH(AW), .SIGNAL_WIDTH(SW)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .ps_alu_en    (ps_alu_en),
        .ps_alu_log   (ps_alu_log),
        .ps_alu_hc    (ps_alu_hc),
        .ps_alu_sc    (ps_alu_sc),
        .ps_alu_sat   (ps_alu_sat),
        .ps_mul_en    (ps_mul_en),
        .ps_mul_otreg (ps_mul_otreg),
        .ps_mul_dtsts (ps_mul_dtsts),
        .ps_mul_cls   (ps_mul_cls),
        .ps_mul_sc    (ps_mul_sc),
        .ps_shf_en    (ps_shf_en),
        .ps_shf_cls   (ps_shf_cls),
        .ps_xb_raddx  (ps_xb_raddx),
        .ps_xb_raddy  (ps_xb_raddy),
        .ps_xb_wadd   (ps_xb_wadd),
        .ps_xb_w_cuEn (ps_xb_w_cuEn),
        .ps_xb_w_bcEn (ps_xb_w_bcEn),
        .busy         (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] ins;
        int          e;   // issue cycle
        int          w;   // writeback cycle
    } rec_t;

    rec_t        q[$];
    int          cyc = 0;
    logic        run_m = 1'b0;
    logic [3:0]  last_wadd = '0;
    logic        last_acc = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_wadd = '0;
        run_m     = 1'b0;
    endtask

    // Compare every output for the current cycle, then record an acceptance.
    task automatic check_cycle();
        logic [7:0]  e_alu;
        logic [9:0]  e_mul;
        logic [2:0]  e_shf;
        logic [7:0]  e_rd;
        logic [7:0]  e_wb;
        logic [2:0]  src;
        logic        e_busy;
        logic        e_rdy;
        logic [31:0] c;
        int          lat;

        while (q.size() > 0 && q[0].w < cyc) q.delete(0);

        e_alu = '0; e_mul = '0; e_shf = '0; e_rd = '0; e_busy = 1'b0;
        e_wb  = {last_wadd, 3'b000, 1'b0};
        foreach (q[k]) begin
            c = q[k].ins;
            if (q[k].e == cyc) begin
                case (c[31:30])
                    2'b00:   e_alu = {1'b1, c[29:23]};
                    2'b01:   e_mul = {1'b1, c[29:21]};
                    2'b10:   e_shf = {1'b1, c[29:28]};
                    default: ;
                endcase
                if (c[31:30] != 2'b11) e_rd = c[7:0];
            end
            if (q[k].w == cyc) begin
                case (c[31:30])
                    2'b00:   src = 3'b001;
                    2'b10:   src = 3'b010;
                    2'b01:   src = 3'b100;
                    default: src = 3'b000;
                endcase
                last_wadd = c[11:8];
                e_wb = {c[11:8], src, c[31:30] == 2'b11};
            end
            if (q[k].w > cyc) e_busy = 1'b1;
        end

        // Readiness: the candidate's writeback cycle must be free.
        lat   = (instr[31:30] == 2'b01) ? 2 : 1;
        e_rdy = run_m;
        foreach (q[k]) begin
            if (q[k].w == cyc + 1 + lat) e_rdy = 1'b0;
`ifdef CU_ISSUE_HAZARD_EN
            if (instr[31:30] != 2'b11 && q[k].w > cyc &&
                (q[k].ins[11:8] == instr[7:4] || q[k].ins[11:8] == instr[3:0]))
                e_rdy = 1'b0;
`endif
        end

        chk("alu_grp", {ps_alu_en, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat}, e_alu);
        chk("mul_grp", {ps_mul_en, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls, ps_mul_sc}, e_mul);
        chk("shf_grp", {ps_shf_en, ps_shf_cls}, e_shf);
        chk("raddxy", {ps_xb_raddx, ps_xb_raddy}, e_rd);
        chk("wb_grp", {ps_xb_wadd, ps_xb_w_cuEn, ps_xb_w_bcEn}, e_wb);
        chk("busy", busy, e_busy);
        chk("instr_ready", instr_ready, e_rdy);

        if (instr_valid && e_rdy) begin
            q.push_back(rec_t'{instr, cyc + 1, cyc + 1 + lat});
            last_acc = 1'b1;
        end else begin
            last_acc = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge with inputs already applied.
    task automatic step();
        #1;
        check_cycle();
        @(posedge clk);
        cyc++;
        if (reset) run_m = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) step();
    endtask

    // Presents w until accepted; waited counts stall cycles.
    task automatic send(input logic [31:0] w, output int waited);
        instr       = w;
        instr_valid = 1'b1;
        waited      = 0;
        step();
        while (!last_acc && waited < 20) begin
            waited++;
            step();
        end
        chk("send_accepted", last_acc, 1);
    endtask

    function automatic logic [31:0] mk(input logic [1:0] u, input logic [3:0] wa,
                                       input logic [3:0] rx, input logic [3:0] ry);
        logic [31:0] v;
        v        = $urandom;
        v[31:30] = u;
        v[11:8]  = wa;
        v[7:4]   = rx;
        v[3:0]   = ry;
        return v;
    endfunction

    function automatic logic [31:0] rand_instr();
        return mk(2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
    endfunction

    // ---------------- directed then random sequence ----------------
    initial begin
        int n;
        int n2;

        // Reset state
        @(negedge clk);
        model_reset();
        idle(3);
        reset = 1'b1;

        // ALU 0x2A00_0123 after reset release
        send(32'h2A00_0123, n);
        instr_valid = 1'b0;
        chk("r24_alu_en", ps_alu_en, 1);
        chk("r24_alu_fields", {ps_alu_log, ps_alu_hc, ps_alu_sc}, {1'b1, 2'd1, 3'd2});
        chk("r24_raddx", ps_xb_raddx, 2);
        chk("r24_raddy", ps_xb_raddy, 3);
        step();
        chk("r24_wadd", ps_xb_wadd, 1);
        chk("r24_cuen", ps_xb_w_cuEn, 3'b001);
        idle(2);

        // MUL then ALU: one bubble, writebacks in separate cycles
        send(mk(2'b01, 4'd5, 4'd1, 4'd2), n);
        send(mk(2'b00, 4'd6, 4'd1, 4'd2), n2);
        chk("r25_bubble", n2, 1);
        chk("r25_mul_cuen", ps_xb_w_cuEn, 3'b100);
        chk("r25_mul_wadd", ps_xb_wadd, 5);
        instr_valid = 1'b0;
        step();
        chk("r25_alu_cuen", ps_xb_w_cuEn, 3'b001);
        chk("r25_alu_wadd", ps_xb_wadd, 6);
        idle(2);

        // Bus load
        send(mk(2'b11, 4'd7, 4'd0, 4'd0), n);
        instr_valid = 1'b0;
        chk("r26_unit_en", {ps_alu_en, ps_mul_en, ps_shf_en}, 3'b000);
        step();
        chk("r26_bc_wb", {ps_xb_wadd, ps_xb_w_cuEn, ps_xb_w_bcEn}, {4'd7, 3'b000, 1'b1});
        idle(2);

        // MUL writes 4, SHF reads 4
        send(mk(2'b01, 4'd4, 4'd0, 4'd1), n);
        send(mk(2'b10, 4'd9, 4'd4, 4'd1), n2);
`ifdef CU_ISSUE_HAZARD_EN
        chk("r27_raw_wait", n2, 2);
`else
        chk("r27_struct_wait", n2, 1);
`endif
        idle(3);

        // Four ALU back to back
        for (int i = 0; i < 4; i++) begin
            send(mk(2'b00, 4'(8 + i), 4'd0, 4'd1), n);
            chk("r29_no_stall", n, 0);
        end
        instr_valid = 1'b0;
        chk("r29_busy_e", busy, 1);
        step();
        chk("r29_busy_w", busy, 0);
        idle(2);

        // Reset during E of a MUL
        send(mk(2'b01, 4'd9, 4'd2, 4'd3), n);
        instr_valid = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        chk("r28_mul_en", ps_mul_en, 0);
        chk("r28_outs", {ps_xb_raddx, ps_xb_raddy, ps_xb_wadd, ps_xb_w_cuEn, ps_xb_w_bcEn}, 0);
        chk("r28_busy", busy, 0);
        chk("r28_ready", instr_ready, 0);
        idle(2);
        reset = 1'b1;
        idle(4);

        // Randomized traffic; source holds a stalled instruction
        for (int i = 0; i < 400; i++) begin
            if (!instr_valid || last_acc) begin
                instr_valid = ($urandom_range(0, 3) != 0);
                instr       = rand_instr();
            end
            step();
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
